// File: rtl/deskew_unloader.sv
// Removes the per-lane skew of the systolic result stream and queues each
// aligned vector for the host side behind a valid/ready handshake.
module deskew_unloader #(
  parameter int DIM       = 8,
  parameter int BITS      = 64,
  parameter int OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DIM*BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIM*BITS-1:0] out_data,
  output logic                busy,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int W  = DIM * BITS;
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [DIM-2:0] vpipe;
  logic           aligned_valid;
  logic [W-1:0]   aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= in_valid;
      for (int s = 1; s < DIM - 1; s++) begin
        vpipe[s] <= vpipe[s-1];
      end
    end
  end

  assign aligned_valid = vpipe[DIM-2];

  // Lane k waits DIM-1-k cycles so every lane lines up with the last one.
  for (genvar k = 0; k < DIM - 1; k++) begin : g_lane
    localparam int N = DIM - 1 - k;
    logic [N-1:0][BITS-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= '0;
      end else begin
        sr[0] <= in_data[k*BITS +: BITS];
        for (int s = 1; s < N; s++) begin
          sr[s] <= sr[s-1];
        end
      end
    end

    assign aligned[k*BITS +: BITS] = sr[N-1];
  end

  assign aligned[(DIM-1)*BITS +: BITS] =
    in_data[(DIM-1)*BITS +: BITS];

  logic [W-1:0]  mem [OUT_DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [PW-1:0] rd_nxt;
  logic [PW-1:0] wr_nxt;

  assign full = (count == CW'(OUT_DEPTH));
  assign pop  = out_valid & out_ready;
  assign push = aligned_valid & (~full | pop);
  assign drop = aligned_valid & full & ~pop;

  assign rd_nxt = (rd == PW'(OUT_DEPTH - 1)) ? '0 : rd + 1'b1;
  assign wr_nxt = (wr == PW'(OUT_DEPTH - 1)) ? '0 : wr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= aligned;
        wr      <= wr_nxt;
      end
      if (pop) begin
        rd <= rd_nxt;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd];
  assign busy      = (|vpipe) | aligned_valid | out_valid;

endmodule
